// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pkg
//  Purpose  : Shared types and sizes for the interrupt priority controller.
//  Revision : 1.0
// ============================================================================
package irq_pkg;

    localparam int NUM_SRC = 8;
    localparam int VEC_W   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/irq_prio_ctrl_prio_enc8.sv
`default_nettype none
// ============================================================================
//  Module   : prio_enc8
//  Purpose  : Combinational 8->3 encoder, highest set index wins, with valid.
//  Revision : 1.0
// ============================================================================
module prio_enc8
    import irq_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    output logic [VEC_W-1:0]   idx,
    output logic               valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        // Ascending scan so the last (highest) set bit overwrites lower ones.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req[i]) idx = VEC_W'(i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_prio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_prio_ctrl
//  Purpose  : 8-source priority interrupt controller, 74148-style cascade.
//  Revision : 1.0
// ============================================================================
module irq_prio_ctrl
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ei_n,
    input  logic [NUM_SRC-1:0] irq_n,
    input  logic [NUM_SRC-1:0] mask,
    input  logic               int_ack,
    input  logic               eoi,
    output logic               int_req,
    output logic [VEC_W-1:0]   vec,
    output logic [NUM_SRC-1:0] in_service,
    output logic               gs_n,
    output logic               eo_n
);

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q, sync_d;
    logic [NUM_SRC-1:0] s;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] eligible;
    logic [VEC_W-1:0]   winner;
    logic               any_elig;

    state_e             state_q, state_d;
    logic               int_req_q, int_req_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [NUM_SRC-1:0] in_service_q, in_service_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_n};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= sync_d;
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic [NUM_SRC-1:0] s_prev_q;
            logic [NUM_SRC-1:0] pending_q, pending_d;
            logic [NUM_SRC-1:0] ack_clr;

            always_comb begin
                ack_clr = '0;
                if (state_q == REQ && int_ack) ack_clr[vec_q] = 1'b1;
                // A fresh falling edge re-arms even if the same source is acked now.
                pending_d = (pending_q & ~ack_clr) | (s_prev_q & ~s);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_prev_q  <= '1;
                    pending_q <= '0;
                end else begin
                    s_prev_q  <= s;
                    pending_q <= pending_d;
                end
            end

            assign pending = pending_q;
        end else begin : g_level
            assign pending = ~s;
        end
    endgenerate

    assign eligible = pending & ~mask & ~in_service_q;

    prio_enc8 u_enc (
        .req   (eligible),
        .idx   (winner),
        .valid (any_elig)
    );

    assign gs_n = ei_n | ~any_elig;
    assign eo_n = ei_n | any_elig;

    always_comb begin
        state_d      = state_q;
        int_req_d    = int_req_q;
        vec_d        = vec_q;
        in_service_d = in_service_q;
        case (state_q)
            IDLE: begin
                if (!ei_n && any_elig) begin
                    state_d   = REQ;
                    int_req_d = 1'b1;
                    vec_d     = winner;
                end
            end
            REQ: begin
                if (int_ack) begin
                    in_service_d[vec_q] = 1'b1;
                    int_req_d           = 1'b0;
                    state_d             = SERVICE;
                end else if (!ei_n && any_elig) begin
                    vec_d = winner;
                end else begin
                    int_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    in_service_d = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                int_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            int_req_q    <= 1'b0;
            vec_q        <= '0;
            in_service_q <= '0;
        end else begin
            state_q      <= state_d;
            int_req_q    <= int_req_d;
            vec_q        <= vec_d;
            in_service_q <= in_service_d;
        end
    end

    assign int_req    = int_req_q;
    assign vec        = vec_q;
    assign in_service = in_service_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_prio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_prio_ctrl
//  Purpose  : Directed self-checking bench, level-mode and edge-mode units.
//  Revision : 1.0
// ============================================================================
module tb_irq_prio_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    int         checks = 0;
    int         fails  = 0;

    logic       ei_n_l, ack_l, eoi_l;
    logic [7:0] irq_n_l, mask_l;
    logic       req_l, gs_n_l, eo_n_l;
    logic [2:0] vec_l;
    logic [7:0] ins_l;

    logic       ei_n_e, ack_e, eoi_e;
    logic [7:0] irq_n_e, mask_e;
    logic       req_e, gs_n_e, eo_n_e;
    logic [2:0] vec_e;
    logic [7:0] ins_e;

    always #5 clk = ~clk;

    irq_prio_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(0)) dut_lvl (
        .clk(clk), .rst_n(rst_n), .ei_n(ei_n_l), .irq_n(irq_n_l), .mask(mask_l),
        .int_ack(ack_l), .eoi(eoi_l), .int_req(req_l), .vec(vec_l),
        .in_service(ins_l), .gs_n(gs_n_l), .eo_n(eo_n_l)
    );

    irq_prio_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(1)) dut_edge (
        .clk(clk), .rst_n(rst_n), .ei_n(ei_n_e), .irq_n(irq_n_e), .mask(mask_e),
        .int_ack(ack_e), .eoi(eoi_e), .int_req(req_e), .vec(vec_e),
        .in_service(ins_e), .gs_n(gs_n_e), .eo_n(eo_n_e)
    );

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ei_n_l = 1'b0; irq_n_l = 8'hFF; mask_l = 8'h00; ack_l = 1'b0; eoi_l = 1'b0;
        ei_n_e = 1'b0; irq_n_e = 8'hFF; mask_e = 8'h00; ack_e = 1'b0; eoi_e = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);
        checks++; if (req_l !== 1'b0) begin fails++; $display("FAIL reset_int_req got=%b exp=0", req_l); end
        checks++; if (gs_n_l !== 1'b1) begin fails++; $display("FAIL reset_gs_n got=%b exp=1", gs_n_l); end
        checks++; if (eo_n_l !== 1'b0) begin fails++; $display("FAIL reset_eo_n got=%b exp=0", eo_n_l); end
        checks++; if (vec_l !== 3'd0) begin fails++; $display("FAIL reset_vec got=%0d exp=0", vec_l); end
        checks++; if (ins_l !== 8'h00) begin fails++; $display("FAIL reset_in_service got=%h exp=00", ins_l); end
        checks++; if (req_e !== 1'b0) begin fails++; $display("FAIL reset_edge_int_req got=%b exp=0", req_e); end
    endtask

    task automatic test_level;
        irq_n_l = 8'hEB;
        step(2);
        checks++; if (req_l !== 1'b0) begin fails++; $display("FAIL lvl_early_req got=%b exp=0", req_l); end
        step(1);
        checks++; if (req_l !== 1'b1) begin fails++; $display("FAIL lvl_req_edge3 got=%b exp=1", req_l); end
        checks++; if (vec_l !== 3'd4) begin fails++; $display("FAIL lvl_vec got=%0d exp=4", vec_l); end
        checks++; if (gs_n_l !== 1'b0) begin fails++; $display("FAIL lvl_gs_n got=%b exp=0", gs_n_l); end
        ack_l = 1'b1; step(1); ack_l = 1'b0;
        checks++; if (ins_l !== 8'h10) begin fails++; $display("FAIL lvl_in_service got=%h exp=10", ins_l); end
        checks++; if (req_l !== 1'b0) begin fails++; $display("FAIL lvl_req_after_ack got=%b exp=0", req_l); end
        // Source 2 is still eligible while 4 is in service, but no nesting request.
        step(2);
        checks++; if (req_l !== 1'b0) begin fails++; $display("FAIL lvl_no_nest got=%b exp=0", req_l); end
        eoi_l = 1'b1; step(1); eoi_l = 1'b0;
        checks++; if (ins_l !== 8'h00) begin fails++; $display("FAIL lvl_eoi_clear got=%h exp=00", ins_l); end
        checks++; if (req_l !== 1'b0) begin fails++; $display("FAIL lvl_req_at_eoi got=%b exp=0", req_l); end
        step(1);
        checks++; if (req_l !== 1'b1) begin fails++; $display("FAIL lvl_rereq got=%b exp=1", req_l); end
        checks++; if (vec_l !== 3'd4) begin fails++; $display("FAIL lvl_rereq_vec got=%0d exp=4", vec_l); end
        irq_n_l = 8'hFF;
        step(4);
        checks++; if (req_l !== 1'b0) begin fails++; $display("FAIL lvl_drop got=%b exp=0", req_l); end
    endtask

    task automatic test_preempt;
        irq_n_l = 8'hFB;
        step(3);
        checks++; if (req_l !== 1'b1 || vec_l !== 3'd2) begin fails++; $display("FAIL pre_first got=%b/%0d exp=1/2", req_l, vec_l); end
        irq_n_l = 8'hBB;
        step(2);
        checks++; if (vec_l !== 3'd2) begin fails++; $display("FAIL pre_hold got=%0d exp=2", vec_l); end
        step(1);
        checks++; if (vec_l !== 3'd6 || req_l !== 1'b1) begin fails++; $display("FAIL pre_switch got=%0d/%b exp=6/1", vec_l, req_l); end
        ack_l = 1'b1; step(1); ack_l = 1'b0;
        checks++; if (ins_l !== 8'h40) begin fails++; $display("FAIL pre_in_service got=%h exp=40", ins_l); end
        irq_n_l = 8'hFF; eoi_l = 1'b1; step(1); eoi_l = 1'b0;
        step(5);
        checks++; if (req_l !== 1'b0 || ins_l !== 8'h00) begin fails++; $display("FAIL pre_cleanup got=%b/%h exp=0/00", req_l, ins_l); end
    endtask

    task automatic test_mask_enable;
        mask_l = 8'h80; irq_n_l = 8'h7F;
        step(4);
        checks++; if (req_l !== 1'b0) begin fails++; $display("FAIL mask_req got=%b exp=0", req_l); end
        checks++; if (eo_n_l !== 1'b0 || gs_n_l !== 1'b1) begin fails++; $display("FAIL mask_cascade got=gs%b eo%b exp=gs1 eo0", gs_n_l, eo_n_l); end
        irq_n_l = 8'hF7;
        step(3);
        checks++; if (req_l !== 1'b1 || vec_l !== 3'd3) begin fails++; $display("FAIL en_req got=%b/%0d exp=1/3", req_l, vec_l); end
        mask_l = 8'h00; ei_n_l = 1'b1;
        #1;
        checks++; if (gs_n_l !== 1'b1 || eo_n_l !== 1'b1) begin fails++; $display("FAIL en_cascade got=gs%b eo%b exp=gs1 eo1", gs_n_l, eo_n_l); end
        step(1);
        checks++; if (req_l !== 1'b0 || vec_l !== 3'd3) begin fails++; $display("FAIL en_drop got=%b/%0d exp=0/3", req_l, vec_l); end
        step(2);
        checks++; if (req_l !== 1'b0) begin fails++; $display("FAIL en_blocked got=%b exp=0", req_l); end
        ei_n_l = 1'b0; irq_n_l = 8'hFF;
        step(4);
        checks++; if (req_l !== 1'b0) begin fails++; $display("FAIL en_cleanup got=%b exp=0", req_l); end
    endtask

    task automatic test_edge;
        irq_n_e = 8'hDF; step(1); irq_n_e = 8'hFF;
        step(2);
        checks++; if (req_e !== 1'b0) begin fails++; $display("FAIL edge_early got=%b exp=0", req_e); end
        step(1);
        checks++; if (req_e !== 1'b1 || vec_e !== 3'd5) begin fails++; $display("FAIL edge_req got=%b/%0d exp=1/5", req_e, vec_e); end
        ack_e = 1'b1; step(1); ack_e = 1'b0;
        checks++; if (ins_e !== 8'h20 || req_e !== 1'b0) begin fails++; $display("FAIL edge_ack got=%h/%b exp=20/0", ins_e, req_e); end
        eoi_e = 1'b1; step(1); eoi_e = 1'b0;
        checks++; if (ins_e !== 8'h00) begin fails++; $display("FAIL edge_eoi got=%h exp=00", ins_e); end
        step(3);
        checks++; if (req_e !== 1'b0) begin fails++; $display("FAIL edge_no_rereq got=%b exp=0", req_e); end
        checks++; if (gs_n_e !== 1'b1 || eo_n_e !== 1'b0) begin fails++; $display("FAIL edge_cascade got=gs%b eo%b exp=gs1 eo0", gs_n_e, eo_n_e); end
    endtask

    task automatic test_async_reset;
        irq_n_l = 8'hFD;
        step(3);
        ack_l = 1'b1; step(1); ack_l = 1'b0;
        checks++; if (ins_l !== 8'h02) begin fails++; $display("FAIL ar_setup got=%h exp=02", ins_l); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ins_l !== 8'h00 || req_l !== 1'b0 || vec_l !== 3'd0) begin
            fails++; $display("FAIL ar_outputs got=%h/%b/%0d exp=00/0/0", ins_l, req_l, vec_l);
        end
        checks++; if (gs_n_l !== 1'b1 || eo_n_l !== 1'b0) begin fails++; $display("FAIL ar_cascade got=gs%b eo%b exp=gs1 eo0", gs_n_l, eo_n_l); end
        irq_n_l = 8'hFF;
        step(1);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        test_reset();
        test_level();
        test_preempt();
        test_mask_enable();
        test_edge();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_prio_ctrl.md
Name: irq_prio_ctrl

Overview:
- 8-source interrupt priority controller built around 74148-style active-low priority encoding.
- Synchronises and latches active-low requests and applies a mask. Selects the highest-index eligible source, with source 7 highest.
- Presents that source to the CPU through a req/ack/EOI handshake and tracks the in-service source.
- Provides 74148-compatible cascade signals (ei_n, eo_n, gs_n) so two units can be chained to give 16 sources.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on irq_n; legal range 2..4.
- EDGE_MODE, 0: 0 = level-sensitive requests; 1 = falling-edge-latched requests.

Ports:
- clk  in  1  system clock; all flops rise-edge.
- rst_n  in  1  asynchronous active-low reset; assertion is immediate, release is synchronous to clk.
- ei_n  in  1  active-low cascade enable in; high blocks new requests.
- irq_n  in  8  active-low request lines, asynchronous to clk; bit 7 is highest priority.
- mask  in  8  1 = source masked; synchronous to clk.
- int_ack  in  1  CPU acknowledge, 1-cycle pulse.
- eoi  in  1  end-of-interrupt, 1-cycle pulse.
- int_req  out  1  registered interrupt request to the CPU.
- vec  out  3  registered index of the presented or in-service source (active-high binary).
- in_service  out  8  registered one-hot in-service source; all zero when none.
- gs_n  out  1  active-low group select: low when ei_n=0 and any source is eligible.
- eo_n  out  1  active-low enable out: low when ei_n=0 and no source is eligible.

Behaviour:
- Reset values:
  - sync flops all 1; pending 0; state IDLE.
  - int_req 0, vec 0, in_service 0.
  - gs_n 1; eo_n follows ei_n.
- Sync: each irq_n bit passes through SYNC_STAGES flops; the output is s[7:0], active-low.
- Pending:
  - EDGE_MODE=0: pending = ~s, recomputed every cycle with no storage.
  - EDGE_MODE=1: pending[i] is set on a 1->0 transition of s[i]. It clears only when source i is acked.
  - Mask gates pending but never clears it.
- eligible = pending & ~mask & ~in_service. The highest set bit is the winner.
- gs_n and eo_n: combinational from eligible and ei_n only. Exact 74148 truth:
  - ei_n=1 -> gs_n=1, eo_n=1.
  - ei_n=0, eligible!=0 -> gs_n=0, eo_n=1.
  - ei_n=0, eligible==0 -> gs_n=1, eo_n=0.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if ei_n=0 and eligible!=0 -> REQ; int_req<=1, vec<=winner.
  - REQ, eligible!=0 and ei_n=0: vec<=winner each cycle, so a higher source arriving before ack replaces the lower one.
  - REQ, eligible==0 or ei_n=1 (and no int_ack that cycle): -> IDLE; int_req<=0; vec holds its last value.
  - REQ, int_ack=1: in_service[vec]<=1; if EDGE_MODE=1, pending[vec]<=0; int_req<=0; -> SERVICE.
    - Ack uses the vec register as it stands that cycle.
    - Ack beats a simultaneous eligible drop or ei_n rise.
  - SERVICE: vec holds.
    - eoi=1: in_service<=0, -> IDLE.
    - Nesting is not supported: no int_req is raised in SERVICE, even for a higher-priority source. gs_n/eo_n still report eligibility.
- Ignored pulses: int_ack outside REQ; eoi outside SERVICE. eoi and int_ack never coincide in a legal state.
- Latency, counted in rising clk edges from the first edge that samples irq_n low:
  - EDGE_MODE=0: int_req high after SYNC_STAGES+1 edges.
  - EDGE_MODE=1: int_req high after SYNC_STAGES+2 edges.
- Return to IDLE after eoi: next request is raised 1 cycle later at earliest.
- Mid-operation reset: all state returns to reset values immediately. Latched edge requests are lost.
- Glitches on irq_n shorter than one clk period may be missed in level mode. This is acceptable.

Decomposition:
- Shared package irq_pkg holds:
  - the state enum (IDLE, REQ, SERVICE);
  - NUM_SRC=8;
  - VEC_W=3.
- One sub-module, prio_enc8: combinational 8->3 highest-index encoder with valid flag. It is instantiated once, on eligible.
- Synchroniser and FSM stay inline.

Test Plan:
- Reset, then ei_n=0 with irq_n=8'hFF -> int_req=0, gs_n=1, eo_n=0, vec=0, in_service=0.
- Level mode, irq_n=8'hEB (sources 4 and 2 low) -> int_req=1 at edge 3, vec=4. int_ack -> in_service=8'h10, int_req=0. eoi -> back to IDLE; int_req=1 again with vec=4 (source 4 still low).
- Preemption before ack: source 2 raised, then source 6 lowered 1 cycle after int_req=1 -> vec changes 2->6 before int_ack. Ack gives in_service=8'h40.
- Mask and enable: mask=8'h80 with irq_n[7]=0 only -> no int_req, eo_n=0. Toggle ei_n=1 during REQ with source 3 -> int_req falls next edge, gs_n=1, eo_n=1.
- Edge mode: 1-cycle-wide (post-sync) low pulse on irq_n[5] -> pending latched, int_req=1 at edge 4, vec=5. Ack clears pending. After eoi, no re-request.
- Async reset asserted in SERVICE with in_service=8'h02 -> all outputs at reset values in the same cycle, without waiting for a clk edge.
